// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI arbiter request path: default request FIFO
// geometry and the bit layout of a captured request payload.
package axi_arb_pkg;

   localparam int REQC_WIDTH = 36;
   localparam int REQC_DEPTH = 4;

   localparam int REQC_ADDR_LSB  = 0;
   localparam int REQC_ADDR_W    = 32;
   localparam int REQC_PROT_LSB  = 32;
   localparam int REQC_PROT_W    = 3;
   localparam int REQC_LOCK_BIT  = 35;

endpackage

// File: rtl/reqc_ram_1r1w.sv
// Generic one-read/one-write RAM: synchronous write, registered read address,
// read data taken from the array through the registered address. No reset.
module reqc_ram_1r1w #(
   parameter  int WIDTH = 36,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [AW-1:0]    ram_radr,
   output logic [WIDTH-1:0] ram_rdata,
   input  logic [AW-1:0]    ram_wadr,
   input  logic [WIDTH-1:0] ram_wdata,
   input  logic             ram_wen
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    radr_q;

   always_ff @(posedge clk) begin
      if (ram_wen) begin
         mem_q[ram_wadr] <= ram_wdata;
      end
      radr_q <= ram_radr;
   end

   assign ram_rdata = mem_q[radr_q];

endmodule

// File: rtl/reqc_fifo_1r1w.sv
// Request-capture FIFO: 1r1w RAM behind a prefetched head register.
// Optional high-water mark output enabled by REQC_FIFO_STAT_EN.
module reqc_fifo_1r1w
   import axi_arb_pkg::*;
#(
   parameter  int WIDTH = REQC_WIDTH,
   parameter  int DEPTH = REQC_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
`ifdef REQC_FIFO_STAT_EN
   ,
   output logic [AW:0]      max_level
`endif
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("reqc_fifo_1r1w: DEPTH must be a power of 2 and >= 2");
   end

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             head_vld_q, head_vld_d;
   logic [WIDTH-1:0] head_q, head_d;

   logic             push, pop, ram_empty, ram_wen;
   logic [AW-1:0]    ram_radr;
   logic [WIDTH-1:0] ram_rdata;

   assign push      = in_valid && in_ready;
   assign pop       = head_vld_q && out_ready;
   // The head register holds one entry; the RAM holds everything behind it.
   assign ram_empty = (level_q == {{AW{1'b0}}, head_vld_q});

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      head_vld_d = head_vld_q;
      head_d     = head_q;
      ram_wen    = 1'b0;

      case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase

      if (pop) begin
         if (!ram_empty) begin
            head_d   = ram_rdata;
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else if (push) begin
            head_d = in_data;
         end else begin
            head_vld_d = 1'b0;
         end
      end

      if (push) begin
         if (!head_vld_q) begin
            head_d     = in_data;
            head_vld_d = 1'b1;
         end else if (!(pop && ram_empty)) begin
            ram_wen  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         head_vld_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         head_vld_q <= head_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      head_q <= head_d;
   end

   // Read address runs one pointer ahead so ram_rdata always shows the next entry.
   assign ram_radr = rst ? '0 : rd_ptr_d;

   reqc_ram_1r1w #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .ram_radr  (ram_radr),
      .ram_rdata (ram_rdata),
      .ram_wadr  (wr_ptr_q),
      .ram_wdata (in_data),
      .ram_wen   (ram_wen)
   );

`ifdef REQC_FIFO_STAT_EN
   logic [AW:0] max_level_q, max_level_d;

   assign max_level_d = (level_d > max_level_q) ? level_d : max_level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         max_level_q <= '0;
      end else begin
         max_level_q <= max_level_d;
      end
   end

   assign max_level = max_level_q;
`endif

   assign full      = (level_q == (AW+1)'(DEPTH));
   assign empty     = (level_q == '0);
   assign in_ready  = !full;
   assign out_valid = head_vld_q;
   assign out_data  = head_q;
   assign level     = level_q;

endmodule

// File: tb/tb_reqc_fifo_1r1w.sv
// Directed and scoreboarded checks of reqc_fifo_1r1w at DEPTH=4 and DEPTH=8.
module tb_reqc_fifo_1r1w;

   logic clk = 1'b0;
   logic rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
   logic [35:0] a_in_data, a_out_data;
   logic [2:0]  a_level;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
   logic [35:0] b_in_data, b_out_data;
   logic [3:0]  b_level;

`ifdef REQC_FIFO_STAT_EN
   logic [2:0]  a_max_level;
   logic [3:0]  b_max_level;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reqc_fifo_1r1w #(.WIDTH(36), .DEPTH(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .level     (a_level),
      .full      (a_full),
      .empty     (a_empty)
`ifdef REQC_FIFO_STAT_EN
      ,
      .max_level (a_max_level)
`endif
   );

   reqc_fifo_1r1w #(.WIDTH(36), .DEPTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .level     (b_level),
      .full      (b_full),
      .empty     (b_empty)
`ifdef REQC_FIFO_STAT_EN
      ,
      .max_level (b_max_level)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [35:0] q[$];
   logic [35:0] prev_data;
   logic        prev_stall, do_push, do_pop;
   int          mx;

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
      tick(); tick();
      rst = 1'b0;

      chk("rst_level",  64'(a_level), 64'd0);
      chk("rst_empty",  64'(a_empty), 64'd1);
      chk("rst_full",   64'(a_full), 64'd0);
      chk("rst_inrdy",  64'(a_in_ready), 64'd1);
      chk("rst_ovld",   64'(a_out_valid), 64'd0);

      // single push, held through a stall
      a_in_valid = 1'b1; a_in_data = 36'h0_1234_5678;
      tick();
      a_in_valid = 1'b0;
      chk("one_ovld",  64'(a_out_valid), 64'd1);
      chk("one_data",  64'(a_out_data), 64'h0_1234_5678);
      chk("one_level", 64'(a_level), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ovld", 64'(a_out_valid), 64'd1);
         chk("stall_data", 64'(a_out_data), 64'h0_1234_5678);
      end
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      chk("one_pop_empty", 64'(a_empty), 64'd1);

      // fill to DEPTH, then an extra push that must be refused
      for (int i = 1; i <= 4; i++) begin
         a_in_valid = 1'b1; a_in_data = 36'(i);
         tick();
      end
      chk("fill_full",  64'(a_full), 64'd1);
      chk("fill_inrdy", 64'(a_in_ready), 64'd0);
      chk("fill_level", 64'(a_level), 64'd4);
      a_in_data = 36'h5;
      tick(); tick();
      a_in_valid = 1'b0;
      chk("fill_block_level", 64'(a_level), 64'd4);
`ifdef REQC_FIFO_STAT_EN
      chk("fill_max", 64'(a_max_level), 64'd4);
`endif
      a_out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_ovld", 64'(a_out_valid), 64'd1);
         chk("drain_data", 64'(a_out_data), 64'(k));
         tick();
      end
      a_out_ready = 1'b0;
      chk("drain_empty", 64'(a_empty), 64'd1);
      chk("drain_ovld0", 64'(a_out_valid), 64'd0);

      // streaming push+pop every cycle
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a_in_data = 36'(i + 36'h100);
         tick();
         chk("strm_ovld",  64'(a_out_valid), 64'd1);
         chk("strm_data",  64'(a_out_data), 64'(i + 36'h100));
         chk("strm_level", 64'(a_level), 64'd1);
      end
      a_in_valid = 1'b0;
      tick();
      a_out_ready = 1'b0;
      chk("strm_end_empty", 64'(a_empty), 64'd1);

      // reset at level 3, then a fresh push
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         a_in_valid = 1'b1; a_in_data = 36'(36'hB0 + i);
         tick();
      end
      a_in_valid = 1'b0;
      chk("mid_level3", 64'(a_level), 64'd3);
`ifdef REQC_FIFO_STAT_EN
      chk("mid_max3", 64'(a_max_level), 64'd3);
`endif
      rst = 1'b1; a_in_valid = 1'b1; a_in_data = 36'hEE; a_out_ready = 1'b1;
      tick();
      rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      chk("mid_rst_level", 64'(a_level), 64'd0);
      chk("mid_rst_ovld",  64'(a_out_valid), 64'd0);
      chk("mid_rst_empty", 64'(a_empty), 64'd1);
`ifdef REQC_FIFO_STAT_EN
      chk("mid_rst_max", 64'(a_max_level), 64'd0);
`endif
      a_in_valid = 1'b1; a_in_data = 36'hA;
      tick();
      a_in_valid = 1'b0;
      chk("post_rst_ovld",  64'(a_out_valid), 64'd1);
      chk("post_rst_data",  64'(a_out_data), 64'hA);
      chk("post_rst_level", 64'(a_level), 64'd1);
`ifdef REQC_FIFO_STAT_EN
      chk("post_rst_max", 64'(a_max_level), 64'd1);
`endif
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
      chk("post_rst_drained", 64'(a_out_valid), 64'd0);

      // random traffic on the DEPTH=8 instance against a queue model
      prev_stall = 1'b0; prev_data = '0; mx = 0;
      for (int c = 0; c < 2000; c++) begin
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_data   = {4'($urandom_range(0, 15)), 32'($urandom)};
         if (prev_stall) chk("rnd_stable", 64'(b_out_data), 64'(prev_data));
         chk("rnd_ovld",  64'(b_out_valid), 64'(q.size() != 0));
         chk("rnd_inrdy", 64'(b_in_ready), 64'(q.size() != 8));
         do_push = b_in_valid && b_in_ready;
         do_pop  = b_out_valid && b_out_ready;
         if (do_pop && q.size() > 0) begin
            chk("rnd_data", 64'(b_out_data), 64'(q[0]));
            void'(q.pop_front());
         end
         if (do_push) q.push_back(b_in_data);
         if (q.size() > mx) mx = q.size();
         prev_stall = b_out_valid && !b_out_ready;
         prev_data  = b_out_data;
         tick();
         chk("rnd_level", 64'(b_level), 64'(q.size()));
`ifdef REQC_FIFO_STAT_EN
         chk("rnd_max", 64'(b_max_level), 64'(mx));
`endif
      end
      b_in_valid = 1'b0; b_out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
